// File: rtl/br_wr_arb.sv
// br_wr_arb: arbitrates the register-file write port between pipeline writeback and
// buffered long-latency results. Define BR_ARB_SCOREBOARD_EN to build the pending-write scoreboard.
module br_wr_arb #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_we,
  input  logic [4:0]  p_a3,
  input  logic [31:0] p_wd,
  output logic        p_stall,
  input  logic        l_valid,
  input  logic [4:0]  l_a3,
  input  logic [31:0] l_wd,
  output logic        l_ready,
  input  logic        iss_v,
  input  logic [4:0]  iss_a,
  input  logic [4:0]  q1,
  input  logic [4:0]  q2,
  output logic        h1,
  output logic        h2,
  output logic        we,
  output logic [4:0]  a3,
  output logic [31:0] wd3
);

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (FIFO_DEPTH != 2 && FIFO_DEPTH != 4) begin : g_bad_depth
    $error("br_wr_arb: FIFO_DEPTH must be 2 or 4");
  end

  typedef struct packed {
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
  } ent_t;

  ent_t             mem_q [FIFO_DEPTH];
  ent_t             head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, empty, push, pop, p_live;
  logic             wr_v;
  logic [AW-1:0]    wr_a;
  logic [DW-1:0]    wr_d;
  logic             we_q, we_d;
  logic [AW-1:0]    a3_q, a3_d;
  logic [DW-1:0]    wd3_q, wd3_d;
  logic             hit1, hit2;

  // Grant selection: a full buffer takes priority so the long unit never deadlocks.
  always_comb begin
    full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    empty   = (cnt_q == '0);
    l_ready = !full;
    push    = l_valid && !full;
    p_live  = p_we && (p_a3 != '0);
    head    = mem_q[rd_ptr_q];
    pop     = 1'b0;
    p_stall = 1'b0;
    wr_v    = 1'b0;
    wr_a    = a3_q;
    wr_d    = wd3_q;
    if (full) begin
      pop     = 1'b1;
      p_stall = p_live;
    end else if (p_live) begin
      wr_v = 1'b1;
      wr_a = p_a3;
      wr_d = p_wd;
    end else if (!empty) begin
      pop = 1'b1;
    end
    // A popped x0 entry is discarded without touching the write port.
    if (pop && (head.a3 != '0)) begin
      wr_v = 1'b1;
      wr_a = head.a3;
      wr_d = head.wd;
    end
    we_d  = wr_v;
    a3_d  = wr_a;
    wd3_d = wr_d;
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Result buffer storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{a3: l_a3, wd: l_wd};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // Registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      we_q  <= we_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
    end
  end

  assign we  = we_q;
  assign a3  = a3_q;
  assign wd3 = wd3_q;

`ifdef BR_ARB_SCOREBOARD_EN
  logic [31:0] pend_q, pend_d;

  // Set after clear so a same-cycle issue to the register just drained keeps it pending.
  always_comb begin
    pend_d = pend_q;
    if (pop && (head.a3 != '0)) pend_d[head.a3] = 1'b0;
    if (iss_v && (iss_a != '0)) pend_d[iss_a] = 1'b1;
    hit1 = pend_q[q1];
    hit2 = pend_q[q2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end
`else
  logic unused_iss;
  assign unused_iss = ^{iss_v, iss_a};
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // The output stage still counts as in flight until the register file absorbs it.
  assign h1 = (q1 != '0) && (hit1 || (we_q && (a3_q == q1)));
  assign h2 = (q2 != '0) && (hit2 || (we_q && (a3_q == q2)));

endmodule

// File: tb/tb_br_wr_arb.sv
// tb_br_wr_arb: random and directed stimulus against a queue-based reference of the write arbiter.
module tb_br_wr_arb;
  localparam int unsigned DEPTH = 2;

  logic        clk, rst_n;
  logic        p_we, l_valid, iss_v;
  logic [4:0]  p_a3, l_a3, iss_a, q1, q2;
  logic [31:0] p_wd, l_wd;
  logic        p_stall, l_ready, h1, h2, we;
  logic [4:0]  a3;
  logic [31:0] wd3;

  br_wr_arb #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_we(p_we), .p_a3(p_a3), .p_wd(p_wd), .p_stall(p_stall),
    .l_valid(l_valid), .l_a3(l_a3), .l_wd(l_wd), .l_ready(l_ready),
    .iss_v(iss_v), .iss_a(iss_a), .q1(q1), .q2(q2), .h1(h1), .h2(h2),
    .we(we), .a3(a3), .wd3(wd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } me_t;

  me_t         mq[$];
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  bit          m_pend[32];
  bit          m_stall_last;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0;
    m_a3 = '0;
    m_wd = '0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
  endtask

  function automatic bit hazard(input logic [4:0] q);
    return (q != 0) && (m_pend[q] || (m_we && m_a3 == q));
  endfunction

  task automatic compare();
    bit e_full;
    e_full = (mq.size() == DEPTH);
    chk("we", 32'(we), 32'(m_we));
    chk("a3", 32'(a3), 32'(m_a3));
    chk("wd3", wd3, m_wd);
    chk("l_ready", 32'(l_ready), 32'(!e_full));
    chk("p_stall", 32'(p_stall), 32'(e_full && p_we && p_a3 != 0));
    chk("h1", 32'(h1), 32'(hazard(q1)));
    chk("h2", 32'(h2), 32'(hazard(q2)));
  endtask

  // What the upcoming rising edge must do, from the priority rules.
  task automatic advance();
    me_t src;
    bit  have, from_fifo, rdy;
    have = 1'b0;
    from_fifo = 1'b0;
    rdy = (mq.size() < DEPTH);
    m_stall_last = !rdy && p_we && p_a3 != 0;
    if (mq.size() == DEPTH) begin
      src = mq.pop_front(); have = 1'b1; from_fifo = 1'b1;
    end else if (p_we && p_a3 != 0) begin
      src = '{p_a3, p_wd}; have = 1'b1;
    end else if (mq.size() > 0) begin
      src = mq.pop_front(); have = 1'b1; from_fifo = 1'b1;
    end
    if (l_valid && rdy) mq.push_back('{l_a3, l_wd});
    m_we = have && src.a != 0;
    if (m_we) begin
      m_a3 = src.a;
      m_wd = src.d;
    end
`ifdef BR_ARB_SCOREBOARD_EN
    if (from_fifo && src.a != 0) m_pend[src.a] = 1'b0;
    if (iss_v && iss_a != 0) m_pend[iss_a] = 1'b1;
`endif
  endtask

  task automatic step(input bit r, input bit pwe, input logic [4:0] pa, input logic [31:0] pd,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld,
                      input bit iv, input logic [4:0] ia, input logic [4:0] qa, input logic [4:0] qb);
    @(negedge clk);
    rst_n = r;
    p_we = pwe; p_a3 = pa; p_wd = pd;
    l_valid = lv; l_a3 = la; l_wd = ld;
    iss_v = iv; iss_a = ia; q1 = qa; q2 = qb;
    #1;
    if (!r) begin
      model_reset();
      m_stall_last = 1'b0;
    end
    compare();
    if (r) advance();
  endtask

  task automatic idle(input logic [4:0] qa, input logic [4:0] qb);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, qa, qb);
  endtask

  initial begin
    bit          r;
    bit          rp_we;
    logic [4:0]  rp_a3;
    logic [31:0] rp_wd;
    rst_n = 1'b0;
    p_we = 0; p_a3 = 0; p_wd = 0; l_valid = 0; l_a3 = 0; l_wd = 0;
    iss_v = 0; iss_a = 0; q1 = 0; q2 = 0;
    model_reset();
    m_stall_last = 1'b0;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_ready", 32'(l_ready), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);

    // Idle contention: pipeline first, buffered result next.
    step(1, 1, 5, 32'h11, 1, 6, 32'h22, 0, 0, 0, 0);
    idle(0, 0);
    chk("c26_1_we", 32'(we), 1); chk("c26_1_a3", 32'(a3), 5); chk("c26_1_wd", wd3, 32'h11);
    idle(0, 0);
    chk("c26_2_we", 32'(we), 1); chk("c26_2_a3", 32'(a3), 6); chk("c26_2_wd", wd3, 32'h22);
    idle(0, 0);
    chk("c26_3_we", 32'(we), 0); chk("c26_3_hold", 32'(a3), 6);

    // Full buffer forces the head out and stalls the pipeline.
    step(1, 1, 9, 32'h99, 1, 7, 32'h77, 0, 0, 0, 0);
    step(1, 1, 9, 32'h99, 1, 8, 32'h88, 0, 0, 0, 0);
    step(1, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0);
    chk("c27_ready", 32'(l_ready), 0); chk("c27_stall", 32'(p_stall), 1);
    step(1, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0);
    chk("c27_x7", 32'(a3), 7); chk("c27_x7d", wd3, 32'h77); chk("c27_nostall", 32'(p_stall), 0);
    idle(0, 0);
    chk("c27_x9", 32'(a3), 9); chk("c27_x9we", 32'(we), 1);
    idle(0, 0);
    chk("c27_x8", 32'(a3), 8); chk("c27_x8d", wd3, 32'h88);
    idle(0, 0);

    // x0 writes are dropped silently.
    step(1, 1, 0, 32'h5, 0, 0, 0, 0, 0, 0, 0);
    chk("c28_stall0", 32'(p_stall), 0);
    step(1, 0, 0, 0, 1, 0, 32'h6, 0, 0, 0, 0);
    chk("c28_we0", 32'(we), 0);
    idle(0, 0);
    chk("c28_we1", 32'(we), 0);
    idle(0, 0);
    chk("c28_we2", 32'(we), 0);
    idle(0, 0);
    chk("c28_we3", 32'(we), 0);

`ifdef BR_ARB_SCOREBOARD_EN
    step(1, 0, 0, 0, 0, 0, 0, 1, 10, 10, 0);
    chk("c29_h_issue", 32'(h1), 0);
    idle(10, 0);
    chk("c29_h_pend", 32'(h1), 1);
    step(1, 0, 0, 0, 1, 10, 32'hAA, 0, 0, 10, 0);
    chk("c29_h_push", 32'(h1), 1);
    idle(10, 0);
    chk("c29_h_grant", 32'(h1), 1);
    idle(10, 0);
    chk("c29_h_out", 32'(h1), 1); chk("c29_a3", 32'(a3), 10);
    idle(10, 0);
    chk("c29_h_done", 32'(h1), 0);
    step(1, 0, 0, 0, 1, 10, 32'hBB, 0, 0, 10, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 10, 10, 0);
    idle(10, 0);
    chk("c29_setwin_a", 32'(h1), 1);
    step(1, 0, 0, 0, 1, 10, 32'hCC, 0, 0, 10, 0);
    chk("c29_setwin_b", 32'(h1), 1);
    idle(10, 0);
    idle(10, 0);
    idle(10, 0);
    chk("c29_clean", 32'(h1), 0);
`endif

    // Reset with a full buffer and pending bits.
    idle(0, 0);
    step(1, 1, 1, 32'h1, 1, 3, 32'h33, 1, 3, 0, 0);
    step(1, 1, 2, 32'h2, 1, 4, 32'h44, 1, 4, 0, 0);
    step(0, 1, 2, 32'h2, 0, 0, 0, 0, 0, 3, 4);
    chk("c30_we", 32'(we), 0); chk("c30_ready", 32'(l_ready), 1);
    chk("c30_h1", 32'(h1), 0); chk("c30_h2", 32'(h2), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    idle(3, 4);
    chk("c30_rel_ready", 32'(l_ready), 1); chk("c30_rel_h1", 32'(h1), 0); chk("c30_rel_h2", 32'(h2), 0);
    idle(3, 4);
    chk("c30_nowr1", 32'(we), 0);
    idle(3, 4);
    chk("c30_nowr2", 32'(we), 0);

    // Randomized traffic; pipeline holds its request while stalled.
    rp_we = 0; rp_a3 = 0; rp_wd = 0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 249) != 0);
      if (!m_stall_last) begin
        rp_we = ($urandom_range(0, 2) != 0);
        rp_a3 = 5'($urandom_range(0, 7));
        rp_wd = $urandom;
      end
      step(r, rp_we, rp_a3, rp_wd,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
